// File: rtl/fe_replay_pkg.sv
// fe_replay_pkg: front-end FIFO command codes and USB status bit positions shared by the
// capture and replay paths, plus a small command-decode helper.
package fe_replay_pkg;

  // Entry command codes.
  localparam logic [1:0] FE_FIFO_CMD_DATA = 2'b00;
  localparam logic [1:0] FE_FIFO_CMD_STAT = 2'b01;
  localparam logic [1:0] FE_FIFO_CMD_TIME = 2'b10;

  // Position of the status field in a FIFO entry, and bit order inside that field.
  localparam int unsigned FE_FIFO_USB_STATUS_BITS_START = 0;
  localparam int unsigned FE_FIFO_USB_STATUS_BITS_LEN   = 5;
  localparam int unsigned FE_FIFO_RXERROR_BIT           = 0;
  localparam int unsigned FE_FIFO_RXACTIVE_BIT          = 1;
  localparam int unsigned FE_FIFO_SESSVLD_BIT           = 2;
  localparam int unsigned FE_FIFO_VBUSVLD_BIT           = 3;
  localparam int unsigned FE_FIFO_SESSEND_BIT           = 4;

  // True for entries that drive the status outputs (DATA and STAT).
  function automatic logic is_event_cmd(input logic [1:0] cmd);
    return (cmd == FE_FIFO_CMD_DATA) || (cmd == FE_FIFO_CMD_STAT);
  endfunction

endpackage

// File: rtl/fe_replay_timer.sv
// fe_replay_timer: loadable down-counter with a zero flag, used to space replayed entries.
module fe_replay_timer #(
  parameter int unsigned Width = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [Width-1:0] value,
  input  logic             dec,
  output logic             zero
);

  localparam logic [Width-1:0] One = {{(Width-1){1'b0}}, 1'b1};

  logic [Width-1:0] count_q;

  // Clear beats load beats decrement; the count holds at zero rather than wrapping.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= value;
    end else if (dec && (count_q != '0)) begin
      count_q <= count_q - One;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/fe_replay.sv
// fe_replay: pops DATA/STAT/TIME entries from a first-word-fall-through FIFO and regenerates
// the fe_* signals with the captured inter-event spacing.
// Optional feature: define FE_REPLAY_EVENT_COUNT_EN to build the DATA+STAT counter on
// O_event_count; otherwise that output is tied to zero.
module fe_replay
  import fe_replay_pkg::*;
#(
  parameter int unsigned pTIMESTAMP_FULL_WIDTH = 16,
  parameter int unsigned pREPLAY_LEN_WIDTH     = 24
) (
  input  logic                                   fe_clk,
  input  logic                                   reset_i,
  input  logic                                   I_enable,
  input  logic [pREPLAY_LEN_WIDTH-1:0]           I_replay_len,
  input  logic                                   I_empty,
  input  logic [1:0]                             I_command,
  input  logic [pTIMESTAMP_FULL_WIDTH-1:0]       I_time,
  input  logic [7:0]                             I_data,
  input  logic [FE_FIFO_USB_STATUS_BITS_LEN-1:0] I_status,
  output logic                                   O_rd,
  output logic [7:0]                             O_fe_data,
  output logic                                   O_fe_rxvalid,
  output logic                                   O_fe_rxactive,
  output logic                                   O_fe_rxerror,
  output logic                                   O_fe_sessvld,
  output logic                                   O_fe_vbusvld,
  output logic                                   O_fe_sessend,
  output logic                                   O_busy,
  output logic                                   O_done,
  output logic                                   O_underrun,
  output logic [23:0]                            O_event_count
);

  typedef enum logic [1:0] {StIdle = 2'd0, StWait = 2'd1, StDone = 2'd2} state_e;

  localparam logic [pTIMESTAMP_FULL_WIDTH-1:0] TimeOne = {{(pTIMESTAMP_FULL_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [pREPLAY_LEN_WIDTH-1:0]     LenOne  = {{(pREPLAY_LEN_WIDTH-1){1'b0}}, 1'b1};

  state_e                           state_q;
  logic                             armed_q;
  logic                             pop_q;
  logic [pREPLAY_LEN_WIDTH-1:0]     entry_cnt_q;
  logic [pREPLAY_LEN_WIDTH-1:0]     entry_cnt_inc;
  logic                             head_ok;
  logic                             head_due;
  logic                             len_hit;
  logic                             tmr_clear;
  logic                             tmr_load;
  logic                             tmr_dec;
  logic                             tmr_zero;
  logic [pTIMESTAMP_FULL_WIDTH-1:0] tmr_value;

  // Pop decision for the head entry and timer controls.
  always_comb begin
    head_ok       = !reset_i && (state_q == StWait) && I_enable && !I_empty;
    // Unarmed: the entry has just reached the head, zero delta pops immediately.
    head_due      = armed_q ? tmr_zero : (I_time == '0);
    O_rd          = head_ok && head_due;
    tmr_clear     = (state_q != StWait) || !I_enable;
    tmr_load      = head_ok && !armed_q && (I_time != '0);
    // The head cycle itself is the first idle cycle, so the timer holds delta-1.
    tmr_value     = I_time - TimeOne;
    tmr_dec       = armed_q && !tmr_zero;
    entry_cnt_inc = entry_cnt_q + LenOne;
    len_hit       = (I_replay_len != '0) && (entry_cnt_inc == I_replay_len);
  end

  fe_replay_timer #(
    .Width(pTIMESTAMP_FULL_WIDTH)
  ) u_timer (
    .clk  (fe_clk),
    .reset(reset_i),
    .clear(tmr_clear),
    .load (tmr_load),
    .value(tmr_value),
    .dec  (tmr_dec),
    .zero (tmr_zero)
  );

  // Run-control FSM with registered replay outputs.
  always_ff @(posedge fe_clk) begin
    if (reset_i) begin
      state_q       <= StIdle;
      armed_q       <= 1'b0;
      pop_q         <= 1'b0;
      entry_cnt_q   <= '0;
      O_fe_data     <= 8'h00;
      O_fe_rxvalid  <= 1'b0;
      O_fe_rxactive <= 1'b0;
      O_fe_rxerror  <= 1'b0;
      O_fe_sessvld  <= 1'b0;
      O_fe_vbusvld  <= 1'b0;
      O_fe_sessend  <= 1'b0;
      O_busy        <= 1'b0;
      O_done        <= 1'b0;
      O_underrun    <= 1'b0;
    end else begin
      O_fe_rxvalid <= 1'b0;
      pop_q        <= O_rd;
      unique case (state_q)
        StIdle: begin
          if (I_enable && !O_done) begin
            state_q <= StWait;
            O_busy  <= 1'b1;
          end
        end
        StWait: begin
          if (!I_enable) begin
            // Abort: the head entry stays in the FIFO, its delta restarts next run.
            state_q <= StIdle;
            O_busy  <= 1'b0;
            armed_q <= 1'b0;
          end else begin
            if (pop_q && I_empty) begin
              O_underrun <= 1'b1;
            end
            if (tmr_load) begin
              armed_q <= 1'b1;
            end
            if (O_rd) begin
              armed_q     <= 1'b0;
              entry_cnt_q <= entry_cnt_inc;
              if (I_command == FE_FIFO_CMD_DATA) begin
                O_fe_rxvalid <= 1'b1;
                O_fe_data    <= I_data;
              end
              if (is_event_cmd(I_command)) begin
                O_fe_rxerror  <= I_status[FE_FIFO_RXERROR_BIT];
                O_fe_rxactive <= I_status[FE_FIFO_RXACTIVE_BIT];
                O_fe_sessvld  <= I_status[FE_FIFO_SESSVLD_BIT];
                O_fe_vbusvld  <= I_status[FE_FIFO_VBUSVLD_BIT];
                O_fe_sessend  <= I_status[FE_FIFO_SESSEND_BIT];
              end
              if (len_hit) begin
                O_done  <= 1'b1;
                O_busy  <= 1'b0;
                state_q <= StDone;
              end
            end
          end
        end
        StDone: begin
          if (!I_enable) begin
            state_q     <= StIdle;
            O_done      <= 1'b0;
            O_underrun  <= 1'b0;
            entry_cnt_q <= '0;
          end
        end
        default: begin
          state_q <= StIdle;
          O_busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef FE_REPLAY_EVENT_COUNT_EN
  logic [23:0] event_cnt_q;

  // Saturating count of DATA+STAT pops, cleared together with the run state on leaving DONE.
  always_ff @(posedge fe_clk) begin
    if (reset_i || ((state_q == StDone) && !I_enable)) begin
      event_cnt_q <= 24'd0;
    end else if (O_rd && is_event_cmd(I_command) && (event_cnt_q != 24'hFF_FFFF)) begin
      event_cnt_q <= event_cnt_q + 24'd1;
    end
  end

  assign O_event_count = event_cnt_q;
`else
  assign O_event_count = 24'd0;
`endif

endmodule
